// File: rtl/dispatch_ctrl_pkg.sv
// Shared definitions for the dispatch controller: decoded op codes, op types,
// the NULL register id and the dispatch FSM state encoding.
package dispatch_ctrl_pkg;

    typedef enum logic [5:0] {
        OP_NOP = 6'd0,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
        OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
    } op_t;

    // TYPE_NONE marks an illegal or unknown instruction word.
    typedef enum logic [2:0] {
        TYPE_NONE = 3'd0,
        IType     = 3'd1,
        ILoadType = 3'd2,
        SType     = 3'd3,
        BType     = 3'd4,
        UType     = 3'd5,
        JType     = 3'd6,
        RType     = 3'd7
    } optype_t;

    localparam logic [5:0] REG_NULL = 6'd32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/dispatch_ctrl_decoder.sv
// Combinational RV32I decoder: op code, op type, immediate and register ids.
// Register fields not used by the format are reported as REG_NULL.
module dispatch_ctrl_decoder
    import dispatch_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output op_t         op,
    output optype_t     typ,
    output logic [31:0] imm,
    output logic [5:0]  rs1,
    output logic [5:0]  rs2,
    output logic [5:0]  rd
);

    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [5:0]  f_rs1, f_rs2, f_rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign f_rs1 = {1'b0, inst[19:15]};
    assign f_rs2 = {1'b0, inst[24:20]};
    assign f_rd  = {1'b0, inst[11:7]};
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'd0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        op  = OP_NOP;
        typ = TYPE_NONE;
        case (inst[6:0])
            7'b0110111: begin op = OP_LUI;   typ = UType; end
            7'b0010111: begin op = OP_AUIPC; typ = UType; end
            7'b1101111: begin op = OP_JAL;   typ = JType; end
            7'b1100111: if (f3 == 3'b000) begin op = OP_JALR; typ = JType; end
            7'b1100011: begin
                typ = BType;
                case (f3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_BLT;
                    3'b101:  op = OP_BGE;
                    3'b110:  op = OP_BLTU;
                    3'b111:  op = OP_BGEU;
                    default: typ = TYPE_NONE;
                endcase
            end
            7'b0000011: begin
                typ = ILoadType;
                case (f3)
                    3'b000:  op = OP_LB;
                    3'b001:  op = OP_LH;
                    3'b010:  op = OP_LW;
                    3'b100:  op = OP_LBU;
                    3'b101:  op = OP_LHU;
                    default: typ = TYPE_NONE;
                endcase
            end
            7'b0100011: begin
                typ = SType;
                case (f3)
                    3'b000:  op = OP_SB;
                    3'b001:  op = OP_SH;
                    3'b010:  op = OP_SW;
                    default: typ = TYPE_NONE;
                endcase
            end
            7'b0010011: begin
                typ = IType;
                case (f3)
                    3'b000: op = OP_ADDI;
                    3'b010: op = OP_SLTI;
                    3'b011: op = OP_SLTIU;
                    3'b100: op = OP_XORI;
                    3'b110: op = OP_ORI;
                    3'b111: op = OP_ANDI;
                    3'b001: if (f7 == 7'b0000000) op = OP_SLLI; else typ = TYPE_NONE;
                    default: begin
                        if (f7 == 7'b0000000)      op = OP_SRLI;
                        else if (f7 == 7'b0100000) op = OP_SRAI;
                        else                       typ = TYPE_NONE;
                    end
                endcase
            end
            7'b0110011: begin
                typ = RType;
                case ({f7, f3})
                    10'b0000000_000: op = OP_ADD;
                    10'b0100000_000: op = OP_SUB;
                    10'b0000000_001: op = OP_SLL;
                    10'b0000000_010: op = OP_SLT;
                    10'b0000000_011: op = OP_SLTU;
                    10'b0000000_100: op = OP_XOR;
                    10'b0000000_101: op = OP_SRL;
                    10'b0100000_101: op = OP_SRA;
                    10'b0000000_110: op = OP_OR;
                    10'b0000000_111: op = OP_AND;
                    default:         typ = TYPE_NONE;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        imm = '0;
        rs1 = REG_NULL;
        rs2 = REG_NULL;
        rd  = REG_NULL;
        case (typ)
            IType: begin
                // Shift-immediates carry only the 5-bit shift amount.
                imm = (op inside {OP_SLLI, OP_SRLI, OP_SRAI}) ? {27'd0, inst[24:20]} : imm_i;
                rs1 = f_rs1;
                rd  = f_rd;
            end
            ILoadType: begin imm = imm_i; rs1 = f_rs1; rd = f_rd; end
            SType:     begin imm = imm_s; rs1 = f_rs1; rs2 = f_rs2; end
            BType:     begin imm = imm_b; rs1 = f_rs1; rs2 = f_rs2; end
            UType:     begin imm = imm_u; rd = f_rd; end
            JType: begin
                rd = f_rd;
                if (op == OP_JALR) begin
                    imm = imm_i;
                    rs1 = f_rs1;
                end else begin
                    imm = imm_j;
                end
            end
            RType:     begin rs1 = f_rs1; rs2 = f_rs2; rd = f_rd; end
            default: ;
        endcase
    end

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch controller: pops one IQ word per cycle into a one-entry hold
// register, then allocates a ROB tag and issues it to the RS or the LSB.
module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int ROB_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             iq_valid_in,
    input  logic [31:0]      iq_inst_in,
    input  logic [31:0]      iq_pc_in,
    input  logic             iq_pred_in,
    output logic             iq_pop_out,
    input  logic             rob_full_in,
    input  logic [ROB_W-1:0] rob_tag_in,
    input  logic             rs_full_in,
    input  logic             lsb_full_in,
    output logic             rob_alloc_out,
    output logic             rs_issue_out,
    output logic             lsb_issue_out,
    output logic             rf_rename_out,
    output logic [5:0]       op_out,
    output logic [2:0]       type_out,
    output logic [31:0]      imm_out,
    output logic [31:0]      pc_out,
    output logic             pred_out,
    output logic [5:0]       rs1_out,
    output logic [5:0]       rs2_out,
    output logic [5:0]       rd_out,
    output logic [ROB_W-1:0] tag_out
);

    state_t state_q, state_d;

    op_t         dec_op;
    optype_t     dec_type;
    logic [31:0] dec_imm;
    logic [5:0]  dec_rs1, dec_rs2, dec_rd;

    op_t              op_q;
    optype_t          type_q;
    logic [31:0]      imm_q, pc_q;
    logic             pred_q;
    logic [5:0]       rs1_q, rs2_q, rd_q;
    logic [ROB_W-1:0] tag_q;

    logic to_lsb, unit_full, issue, pop;

    dispatch_ctrl_decoder u_decoder (
        .inst (iq_inst_in),
        .op   (dec_op),
        .typ  (dec_type),
        .imm  (dec_imm),
        .rs1  (dec_rs1),
        .rs2  (dec_rs2),
        .rd   (dec_rd)
    );

    assign to_lsb    = (type_q == ILoadType) || (type_q == SType);
    assign unit_full = to_lsb ? lsb_full_in : rs_full_in;
    assign issue     = (state_q == ST_HOLD) && rdy_in && !flush_in && !rob_full_in && !unit_full;
    // Popping while issuing replaces the held entry at the same edge: no bubble.
    assign pop       = rdy_in && !flush_in && iq_valid_in && ((state_q == ST_EMPTY) || issue);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (rdy_in) begin
            if (flush_in)   state_d = ST_EMPTY;
            else if (pop)   state_d = (dec_type == TYPE_NONE) ? ST_HALT : ST_HOLD;
            else if (issue) state_d = ST_EMPTY;
        end
    end

    always_comb begin
        iq_pop_out    = pop;
        rob_alloc_out = issue;
        lsb_issue_out = issue && to_lsb;
        rs_issue_out  = issue && !to_lsb;
        rf_rename_out = issue && (rd_q != REG_NULL) && (rd_q != 6'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the payload is reset as well so the backend never sees X before the first pop.
        if (!rst_n) begin
            op_q   <= OP_NOP;
            type_q <= TYPE_NONE;
            imm_q  <= '0;
            pc_q   <= '0;
            pred_q <= 1'b0;
            rs1_q  <= REG_NULL;
            rs2_q  <= REG_NULL;
            rd_q   <= REG_NULL;
            tag_q  <= '0;
        end else if (pop) begin
            op_q   <= dec_op;
            type_q <= dec_type;
            imm_q  <= dec_imm;
            pc_q   <= iq_pc_in;
            pred_q <= iq_pred_in;
            rs1_q  <= dec_rs1;
            rs2_q  <= dec_rs2;
            rd_q   <= dec_rd;
            tag_q  <= rob_tag_in;
        end else if (rdy_in && !flush_in && (state_q == ST_HOLD)) begin
            // Follow the ROB tail while waiting for a free slot.
            tag_q  <= rob_tag_in;
        end
    end

    assign op_out   = op_q;
    assign type_out = type_q;
    assign imm_out  = imm_q;
    assign pc_out   = pc_q;
    assign pred_out = pred_q;
    assign rs1_out  = rs1_q;
    assign rs2_out  = rs2_q;
    assign rd_out   = rd_q;
    assign tag_out  = tag_q;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: a cycle table for the issue stream plus
// hand-written sequences for stall, flush, halt, freeze and async reset.
module tb_dispatch_ctrl;
    import dispatch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy_in, flush_in, iq_valid_in, iq_pred_in;
    logic [31:0] iq_inst_in, iq_pc_in;
    logic        iq_pop_out;
    logic        rob_full_in, rs_full_in, lsb_full_in;
    logic [3:0]  rob_tag_in;
    logic        rob_alloc_out, rs_issue_out, lsb_issue_out, rf_rename_out;
    logic [5:0]  op_out;
    logic [2:0]  type_out;
    logic [31:0] imm_out, pc_out;
    logic        pred_out;
    logic [5:0]  rs1_out, rs2_out, rd_out;
    logic [3:0]  tag_out;

    logic [4:0]  strb;
    int          total = 0;
    int          bad   = 0;

    localparam logic [31:0] I_ADDI5 = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] I_LW    = 32'h0000a103;  // lw   x2,0(x1)
    localparam logic [31:0] I_ADD   = 32'h002081b3;  // add  x3,x1,x2
    localparam logic [31:0] I_SW    = 32'h0020a423;  // sw   x2,8(x1)
    localparam logic [31:0] I_BEQ   = 32'h00208863;  // beq  x1,x2,+16
    localparam logic [31:0] I_ADDM1 = 32'hfff00213;  // addi x4,x0,-1
    localparam logic [31:0] I_LUI   = 32'h123452b7;  // lui  x5,0x12345
    localparam logic [31:0] I_NOP   = 32'h00000013;  // addi x0,x0,0

    dispatch_ctrl #(.ROB_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rdy_in        (rdy_in),
        .flush_in      (flush_in),
        .iq_valid_in   (iq_valid_in),
        .iq_inst_in    (iq_inst_in),
        .iq_pc_in      (iq_pc_in),
        .iq_pred_in    (iq_pred_in),
        .iq_pop_out    (iq_pop_out),
        .rob_full_in   (rob_full_in),
        .rob_tag_in    (rob_tag_in),
        .rs_full_in    (rs_full_in),
        .lsb_full_in   (lsb_full_in),
        .rob_alloc_out (rob_alloc_out),
        .rs_issue_out  (rs_issue_out),
        .lsb_issue_out (lsb_issue_out),
        .rf_rename_out (rf_rename_out),
        .op_out        (op_out),
        .type_out      (type_out),
        .imm_out       (imm_out),
        .pc_out        (pc_out),
        .pred_out      (pred_out),
        .rs1_out       (rs1_out),
        .rs2_out       (rs2_out),
        .rd_out        (rd_out),
        .tag_out       (tag_out)
    );

    always #5 clk = ~clk;

    // Strobe vector order: {pop, alloc, rs, lsb, rename}
    assign strb = {iq_pop_out, rob_alloc_out, rs_issue_out, lsb_issue_out, rf_rename_out};

    typedef struct {
        logic        v;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        robf;
        logic        rsf;
        logic        lsbf;
        logic [4:0]  e_strb;
        logic [5:0]  e_op;
        logic [31:0] e_imm;
        logic [5:0]  e_rd;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, return at the falling edge.
    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic robf, input logic rsf, input logic lsbf,
                        input logic fl, input logic rdy, input logic pred, input logic [3:0] tag);
        @(posedge clk);
        #1;
        iq_valid_in = v;
        iq_inst_in  = inst;
        iq_pc_in    = pc;
        rob_full_in = robf;
        rs_full_in  = rsf;
        lsb_full_in = lsbf;
        flush_in    = fl;
        rdy_in      = rdy;
        iq_pred_in  = pred;
        rob_tag_in  = tag;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //         v     inst     pc         robf  rsf   lsbf  strb      op         imm            rd        pc
        tbl[0]  = '{1'b1, I_ADDI5, 32'h100, 1'b0, 1'b0, 1'b0, 5'b10000, OP_NOP,  32'h0,        REG_NULL, 32'h0};
        tbl[1]  = '{1'b1, I_ADD,   32'h104, 1'b0, 1'b0, 1'b0, 5'b11101, OP_ADDI, 32'h5,        6'd1,     32'h100};
        tbl[2]  = '{1'b1, I_SW,    32'h108, 1'b0, 1'b0, 1'b0, 5'b11101, OP_ADD,  32'h0,        6'd3,     32'h104};
        tbl[3]  = '{1'b1, I_BEQ,   32'h10c, 1'b0, 1'b0, 1'b0, 5'b11010, OP_SW,   32'h8,        REG_NULL, 32'h108};
        tbl[4]  = '{1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 5'b01100, OP_BEQ,  32'h10,       REG_NULL, 32'h10c};
        tbl[5]  = '{1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 5'b00000, OP_BEQ,  32'h10,       REG_NULL, 32'h10c};
        tbl[6]  = '{1'b1, I_ADDM1, 32'h110, 1'b1, 1'b0, 1'b0, 5'b10000, OP_BEQ,  32'h10,       REG_NULL, 32'h10c};
        tbl[7]  = '{1'b1, I_LUI,   32'h114, 1'b1, 1'b0, 1'b0, 5'b00000, OP_ADDI, 32'hffffffff, 6'd4,     32'h110};
        tbl[8]  = '{1'b1, I_LUI,   32'h114, 1'b0, 1'b0, 1'b0, 5'b11101, OP_ADDI, 32'hffffffff, 6'd4,     32'h110};
        tbl[9]  = '{1'b1, I_NOP,   32'h118, 1'b0, 1'b1, 1'b0, 5'b00000, OP_LUI,  32'h12345000, 6'd5,     32'h114};
        tbl[10] = '{1'b1, I_NOP,   32'h118, 1'b0, 1'b0, 1'b1, 5'b11101, OP_LUI,  32'h12345000, 6'd5,     32'h114};
        tbl[11] = '{1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 5'b01100, OP_ADDI, 32'h0,        6'd0,     32'h118};
        tbl[12] = '{1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 5'b00000, OP_ADDI, 32'h0,        6'd0,     32'h118};

        rst_n       = 1'b0;
        rdy_in      = 1'b1;
        flush_in    = 1'b0;
        iq_valid_in = 1'b0;
        iq_inst_in  = '0;
        iq_pc_in    = '0;
        iq_pred_in  = 1'b0;
        rob_full_in = 1'b0;
        rob_tag_in  = '0;
        rs_full_in  = 1'b0;
        lsb_full_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        check("reset_strb", 32'(strb), 32'h0);
        check("reset_rd", 32'(rd_out), 32'(REG_NULL));
        check("reset_rs1", 32'(rs1_out), 32'(REG_NULL));
        check("reset_rs2", 32'(rs2_out), 32'(REG_NULL));
        check("reset_op", 32'(op_out), 32'h0);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].v, tbl[i].inst, tbl[i].pc, tbl[i].robf, tbl[i].rsf, tbl[i].lsbf,
                 1'b0, 1'b1, 1'b0, 4'd0);
            check($sformatf("row%0d_strb", i), 32'(strb), 32'(tbl[i].e_strb));
            check($sformatf("row%0d_op", i), 32'(op_out), 32'(tbl[i].e_op));
            check($sformatf("row%0d_imm", i), imm_out, tbl[i].e_imm);
            check($sformatf("row%0d_rd", i), 32'(rd_out), 32'(tbl[i].e_rd));
            check($sformatf("row%0d_pc", i), pc_out, tbl[i].e_pc);
        end

        // lw stalled three cycles by a full LSB, tag follows the ROB tail.
        step(1'b1, I_LW, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5);
        check("lw_pop", 32'(strb), 32'b10000);
        step(1'b1, I_ADDI5, 32'h204, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6);
        check("lw_stall1_strb", 32'(strb), 32'b00000);
        check("lw_op", 32'(op_out), 32'(OP_LW));
        check("lw_rd", 32'(rd_out), 32'd2);
        check("lw_rs1", 32'(rs1_out), 32'd1);
        check("lw_type", 32'(type_out), 32'(ILoadType));
        check("lw_pred", 32'(pred_out), 32'd1);
        check("lw_tag_pop", 32'(tag_out), 32'd5);
        step(1'b1, I_ADDI5, 32'h204, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6);
        check("lw_stall2_strb", 32'(strb), 32'b00000);
        check("lw_tag_track", 32'(tag_out), 32'd6);
        step(1'b1, I_ADDI5, 32'h204, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6);
        check("lw_stall3_strb", 32'(strb), 32'b00000);
        step(1'b1, I_ADDI5, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6);
        check("lw_issue_strb", 32'(strb), 32'b11011);
        check("lw_issue_op", 32'(op_out), 32'(OP_LW));
        check("lw_issue_pc", pc_out, 32'h200);

        // Flush while holding addi: nothing issues, payload kept.
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        check("flush_strb", 32'(strb), 32'b00000);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("post_flush_strb", 32'(strb), 32'b00000);
        check("post_flush_op", 32'(op_out), 32'(OP_ADDI));
        check("post_flush_pc", pc_out, 32'h204);

        // All-zero word halts dispatch until a flush.
        step(1'b1, 32'h0, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("halt_pop", 32'(strb), 32'b10000);
        step(1'b1, I_ADDI5, 32'h304, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("halt1_strb", 32'(strb), 32'b00000);
        check("halt_type", 32'(type_out), 32'h0);
        step(1'b1, I_ADDI5, 32'h304, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("halt2_strb", 32'(strb), 32'b00000);
        step(1'b1, I_ADDI5, 32'h304, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        check("halt_flush_strb", 32'(strb), 32'b00000);
        step(1'b1, I_ADDI5, 32'h304, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("resume_pop", 32'(strb), 32'b10000);

        // rdy_in low freezes everything, even with flush_in high.
        step(1'b1, I_ADD, 32'h308, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check("frozen_strb", 32'(strb), 32'b00000);
        check("frozen_op", 32'(op_out), 32'(OP_ADDI));
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("unfrozen_strb", 32'(strb), 32'b01101);
        check("unfrozen_pc", pc_out, 32'h304);

        // Asynchronous reset while holding drops the instruction.
        step(1'b1, I_LW, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9);
        check("rst_pop", 32'(strb), 32'b10000);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9);
        check("rst_hold_rd", 32'(rd_out), 32'd2);
        rst_n = 1'b0;
        #1;
        check("rst_async_rd", 32'(rd_out), 32'(REG_NULL));
        check("rst_async_pc", pc_out, 32'h0);
        check("rst_async_tag", 32'(tag_out), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("rst_after_strb", 32'(strb), 32'b00000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
